// File: rtl/onchip_ram_vec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : onchip_ram_vec_pkg
// Purpose  : Shared FSM state type and default sizing for the RAM vector reader.
// Revision : 1.0
// ============================================================================
package onchip_ram_vec_pkg;

    localparam int C_DEF_DATA_W     = 64;
    localparam int C_DEF_ADDR_W     = 5;
    localparam int C_DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/onchip_ram_vec_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : onchip_ram_vec_reader_if
// Purpose  : RAM read port plus Avalon-ST source bundle of the vector reader.
// Revision : 1.0
// ============================================================================
interface onchip_ram_vec_reader_if
    import onchip_ram_vec_pkg::*;
#(
    parameter int DATA_W = C_DEF_DATA_W,
    parameter int ADDR_W = C_DEF_ADDR_W
) ();

    logic [ADDR_W-1:0]   ram_address;
    logic                ram_chipselect;
    logic                ram_write;
    logic [DATA_W/8-1:0] ram_byteenable;
    logic                ram_clken;
    logic [DATA_W-1:0]   ram_readdata;

    logic                st_valid;
    logic                st_ready;
    logic [DATA_W-1:0]   st_data;
    logic                st_startofpacket;
    logic                st_endofpacket;

    modport master (
        output ram_address, ram_chipselect, ram_write, ram_byteenable, ram_clken,
        input  ram_readdata,
        output st_valid, st_data, st_startofpacket, st_endofpacket,
        input  st_ready
    );

    modport slave (
        input  ram_address, ram_chipselect, ram_write, ram_byteenable, ram_clken,
        output ram_readdata,
        input  st_valid, st_data, st_startofpacket, st_endofpacket,
        output st_ready
    );

endinterface
`default_nettype wire

// File: rtl/onchip_ram_vec_fifo.sv
`default_nettype none
// ============================================================================
// Module   : onchip_ram_vec_fifo
// Purpose  : Synchronous show-ahead FIFO with occupancy count.
// Revision : 1.0
// ============================================================================
module onchip_ram_vec_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  wire logic                   clk,
    input  wire logic                   reset_n,
    input  wire logic                   i_push,
    input  wire logic [DATA_W-1:0]      i_data,
    input  wire logic                   i_pop,
    output logic      [DATA_W-1:0]      o_data,
    output logic                        o_empty,
    output logic      [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_full;
    logic              w_do_pop;

    assign w_full   = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_do_pop = i_pop && !o_empty;
    assign o_data   = r_mem[r_rd_ptr];
    assign o_count  = r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // The reader's credit rule must keep pushes away from a full buffer
            assert (!(i_push && w_full));
            if (i_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && i_push)
            r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/onchip_ram_vec_reader.sv
`default_nettype none
// ============================================================================
// Module   : onchip_ram_vec_reader
// Purpose  : Streams a run of on-chip RAM words out as one Avalon-ST packet.
// Revision : 1.0
// ============================================================================
module onchip_ram_vec_reader
    import onchip_ram_vec_pkg::*;
#(
    parameter int DATA_W     = C_DEF_DATA_W,
    parameter int ADDR_W     = C_DEF_ADDR_W,
    parameter int FIFO_DEPTH = C_DEF_FIFO_DEPTH
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] base_addr,
    input  wire logic [ADDR_W:0]   length,
    output logic                   busy,
    output logic                   done,
    onchip_ram_vec_reader_if.master bus
);

    localparam int            CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0] C_MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_issued;
    logic [ADDR_W:0]   r_accepted;
    logic              r_inflight;
    logic              r_done;

    logic [ADDR_W:0]   w_len_clamped;
    logic              w_credit_ok;
    logic              w_issue;
    logic              w_hs;
    logic              w_last_hs;
    logic              w_valid;
    logic [DATA_W-1:0] w_fifo_data;
    logic [CNT_W-1:0]  w_fifo_count;

    assign w_len_clamped = (length > C_MAX_LEN) ? C_MAX_LEN : length;
    // Words in the buffer plus the one read in flight may never exceed its depth
    assign w_credit_ok   = (32'(w_fifo_count) + 32'(r_inflight)) < 32'(FIFO_DEPTH);
    assign w_issue       = (r_state == ST_RUN) && (r_issued < r_len) && w_credit_ok;
    assign w_hs          = w_valid && bus.st_ready;
    assign w_last_hs     = (r_state == ST_DRAIN) && w_hs && (r_accepted == r_len - 1'b1);

    onchip_ram_vec_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (r_inflight),
        .i_data  (bus.ram_readdata),
        .i_pop   (w_hs),
        .o_data  (w_fifo_data),
        .o_empty (),
        .o_count (w_fifo_count)
    );

    assign w_valid = (w_fifo_count != '0);

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (start && (w_len_clamped != '0)) w_state_next = ST_RUN;
            ST_RUN:   if (w_issue && (r_issued == r_len - 1'b1)) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_last_hs) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy                 = (r_state != ST_IDLE);
        done                 = r_done;
        bus.ram_chipselect   = w_issue;
        bus.ram_address      = w_issue ? (r_base + r_issued[ADDR_W-1:0]) : '0;
        bus.st_valid         = w_valid;
        bus.st_data          = w_fifo_data;
        bus.st_startofpacket = w_valid && (r_accepted == '0);
        bus.st_endofpacket   = w_valid && (r_accepted == r_len - 1'b1);
    end

    assign bus.ram_write      = 1'b0;
    assign bus.ram_byteenable = '1;
    assign bus.ram_clken      = 1'b1;

    // Clearing r_inflight on reset drops any read still returning from the RAM
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_accepted <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_done     <= w_last_hs ||
                          ((r_state == ST_IDLE) && start && (w_len_clamped == '0));
            if ((r_state == ST_IDLE) && start) begin
                r_base     <= base_addr;
                r_len      <= w_len_clamped;
                r_issued   <= '0;
                r_accepted <= '0;
            end else begin
                if (w_issue)
                    r_issued <= r_issued + 1'b1;
                if (w_hs)
                    r_accepted <= r_accepted + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onchip_ram_vec_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_onchip_ram_vec_reader
// Purpose  : Randomized self-checking bench with a job-level scoreboard model.
// Revision : 1.0
// ============================================================================
module tb_onchip_ram_vec_reader;
    import onchip_ram_vec_pkg::*;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int NWORDS = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   length = '0;
    logic              busy;
    logic              done;

    onchip_ram_vec_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    onchip_ram_vec_reader #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // RAM: one-cycle read latency, garbage on cycles with no read
    logic [63:0] ram [NWORDS];
    always @(posedge clk)
        bus.ram_readdata <= bus.ram_chipselect ? ram[bus.ram_address] : {$urandom, $urandom};

    bit   ready_mode = 1'b0;
    logic ready_val  = 1'b1;
    initial begin
        bus.st_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.st_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    // Scoreboard: expected addresses and beats of the accepted job
    logic [ADDR_W-1:0] exp_addr [$];
    logic [63:0]       exp_data [$];
    bit mon_en = 1'b0, model_busy = 1'b0, busy_at_entry, exp_done_next = 1'b0, seen_valid;
    int cyc = 0, job_len = 0, beat_idx = 0, issued = 0, popped = 0, done_seen = 0;
    int first_cs_cyc = 0, first_beat_cyc = 0, last_beat_cyc = 0, clen;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            busy_at_entry = model_busy;
            check("done", done, exp_done_next);
            if (done) done_seen++;
            exp_done_next = 1'b0;
            if (bus.ram_chipselect) begin
                if (exp_addr.size() == 0) check("extra_read", 1, 0);
                else check("addr", bus.ram_address, exp_addr.pop_front());
                if (issued == 0) first_cs_cyc = cyc;
                issued++;
                check("credit", (issued - popped) <= DEPTH, 1);
            end
            if (bus.st_valid) begin
                if (exp_data.size() == 0) check("extra_beat", 1, 0);
                else begin
                    check("data", bus.st_data, exp_data[0]);
                    check("sop", bus.st_startofpacket, beat_idx == 0);
                    check("eop", bus.st_endofpacket, beat_idx == job_len - 1);
                    if (!seen_valid) check("latency", cyc - first_cs_cyc, 2);
                    seen_valid = 1'b1;
                    if (bus.st_ready) begin
                        void'(exp_data.pop_front());
                        if (beat_idx == 0) first_beat_cyc = cyc;
                        last_beat_cyc = cyc;
                        popped++;
                        beat_idx++;
                        if (beat_idx == job_len) begin
                            model_busy    = 1'b0;
                            exp_done_next = 1'b1;
                        end
                    end
                end
            end
            if (reset_n && start && !busy_at_entry) begin
                clen = (int'(length) > NWORDS) ? NWORDS : int'(length);
                if (clen == 0) exp_done_next = 1'b1;
                else begin
                    model_busy = 1'b1;
                    job_len = clen; beat_idx = 0; issued = 0; popped = 0; seen_valid = 1'b0;
                    for (int i = 0; i < clen; i++) begin
                        exp_addr.push_back(ADDR_W'((int'(base_addr) + i) % NWORDS));
                        exp_data.push_back(ram[(int'(base_addr) + i) % NWORDS]);
                    end
                end
            end
            if (!reset_n) begin
                model_busy = 1'b0;
                exp_done_next = 1'b0;
                exp_addr.delete();
                exp_data.delete();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int b, input int l);
        base_addr = ADDR_W'(b);
        length    = (ADDR_W+1)'(l);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_seen < target && n < budget) begin
            tick();
            n++;
        end
        check("job_timeout", done_seen >= target, 1);
        @(negedge clk);
        check("busy_idle", busy, 0);
        check("leftover", exp_data.size(), 0);
        tick();
    endtask

    task automatic run_job(input int b, input int l);
        int target = done_seen + 1;
        pulse_start(b, l);
        @(negedge clk);
        check("busy_on", busy, (l != 0));
        tick();
        wait_done(target, 300);
    endtask

    task automatic check_outputs_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cs"}, bus.ram_chipselect, 0);
        check({tag, "_addr"}, bus.ram_address, 0);
        check({tag, "_valid"}, bus.st_valid, 0);
        check({tag, "_sopeop"}, {bus.st_startofpacket, bus.st_endofpacket}, 0);
    endtask

    initial begin
        int target, n;
        for (int i = 0; i < NWORDS; i++) ram[i] = 64'(i);
        repeat (3) tick();
        @(negedge clk);
        check_outputs_idle("reset");
        check("tieoffs", {bus.ram_write, bus.ram_byteenable, bus.ram_clken}, {1'b0, 8'hFF, 1'b1});
        tick();
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick();

        run_job(0, 4);
        check("burst_0_4", last_beat_cyc - first_beat_cyc, 3);
        run_job(30, 4);
        check("burst_wrap", last_beat_cyc - first_beat_cyc, 3);

        // Back-pressure window on cycles 3..10 after start
        target = done_seen + 1;
        pulse_start(7, 8);
        for (int k = 1; k <= 12; k++) begin
            ready_val = !(k >= 3 && k <= 10);
            tick();
        end
        ready_val = 1'b1;
        wait_done(target, 100);
        check("bp_beats", beat_idx, 8);

        run_job(5, 0);
        run_job(3, 40);
        check("clamp_beats", beat_idx, 32);

        // Second start mid-job must be ignored
        target = done_seen + 1;
        pulse_start(2, 6);
        n = 0;
        while (beat_idx < 2 && n < 50) begin tick(); n++; end
        pulse_start(9, 3);
        wait_done(target, 100);
        repeat (5) tick();
        check("one_done", done_seen, target);
        check("mid_start_beats", beat_idx, 6);

        // Reset at beat 2 abandons the job
        pulse_start(10, 8);
        n = 0;
        while (beat_idx < 2 && n < 50) begin tick(); n++; end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check_outputs_idle("midreset");
        tick();
        repeat (4) tick();
        run_job(0, 5);

        ready_mode = 1'b1;
        for (int j = 0; j < 25; j++) begin
            for (int i = 0; i < NWORDS; i++) ram[i] = {$urandom, $urandom};
            target = done_seen + 1;
            pulse_start($urandom_range(0, NWORDS - 1), $urandom_range(0, 40));
            n = 0;
            while (done_seen < target && n < 400) begin
                if (model_busy && $urandom_range(0, 9) == 0) begin
                    base_addr = ADDR_W'($urandom);
                    length    = (ADDR_W+1)'($urandom);
                    start     = 1'b1;
                end else start = 1'b0;
                tick();
                n++;
            end
            start = 1'b0;
            wait_done(target, 10);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
